mul_seq_ctl: RTL
================

# mul_seq_ctl

Sequencer for the 32-step shift-add multiplier and the HiLo register pair. It accepts a `multu` issue from decode and loads the operands once. It steps the multiplier exactly WIDTH times, then opens HiLo for one write cycle. It interlocks `mfhi`/`mflo` and back-to-back `multu` against an in-flight multiply, and lets all other instructions proceed.

## Interface
Parameters:
- WIDTH, 32, operand width; also the number of multiply steps
- CNT_W, 6, step-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  decode presents a valid instruction this cycle
- funct  in  6  function field of the presented instruction
- mul_load  out  1  load multiplicand/multiplier/product registers
- mul_step  out  1  perform one shift-add step
- hilo_wr  out  1  write product into Hi/Lo (HiLo open)
- mul_op  out  6  operation code to multiplier/HiLo mux
- step_cnt  out  CNT_W  steps completed in the current multiply
- busy  out  1  multiply in flight (state ≠ IDLE)
- stall  out  1  hold PC/decode this cycle
- done  out  1  one-cycle pulse coincident with hilo_wr

Clock and reset are fixed: one clock `clk`; `rst` is synchronous and active-high.

## Operation
- States: IDLE, LOAD, RUN, WRITE.
- accept = issue_valid & (funct == F_MULTU) & (state == IDLE).
- IDLE:
  - On accept, go to LOAD and clear step_cnt to 0.
  - Otherwise stay in IDLE.
- LOAD:
  - mul_load=1 and mul_op=F_MULTU for one cycle.
  - Next state is always RUN.
- RUN:
  - mul_step=1 and mul_op=F_MULTU.
  - step_cnt increments every cycle.
  - When step_cnt == WIDTH-1 this cycle, step_cnt becomes WIDTH and the next state is WRITE.
- WRITE:
  - hilo_wr=1, done=1 and mul_op=HILO_OPEN (6'b111111) for one cycle.
  - Next state is IDLE; step_cnt holds WIDTH until the next accept.
- mul_op is 6'd0 in IDLE.
- stall is combinational: stall = busy & issue_valid & (funct ∈ {F_MULTU, F_MFHI, F_MFLO}).
  - Any other funct while busy produces stall=0, and that instruction proceeds.
- An accepting `multu` in IDLE is not stalled: it issues and the sequencer owns the multiplier from then on.
- `mfhi`/`mflo` arriving in the WRITE cycle still stall. They issue in the following IDLE cycle and read the new HiLo value.
- The counter never wraps. With CNT_W ≥ clog2(WIDTH+1), no overflow occurs.
- funct is sampled only in IDLE. Changes during LOAD/RUN/WRITE do not alter the sequence.

## Timing
- Reset values: state=IDLE, step_cnt=0, and all 1-bit outputs 0.
- mul_op resets to 0.
- Reset asserted in any state returns to IDLE at the next edge. A partial product is abandoned and hilo_wr is never asserted for it.
- Latency, with accept at cycle T:
  - T+1: LOAD
  - T+2 … T+WIDTH+1: RUN, 32 mul_step cycles for WIDTH=32
  - T+WIDTH+2: WRITE, with hilo_wr/done
  - T+WIDTH+3: IDLE, earliest next accept
- All outputs except stall are registered-state decodes and stable for the whole cycle.
- stall depends combinationally on issue_valid/funct.

## Structure
- Shared package `mul_pkg` holds:
  - F_MULTU = 6'd25
  - F_MFHI = 6'd16
  - F_MFLO = 6'd18
  - HILO_OPEN = 6'b111111
  - the 2-bit state encoding (IDLE=0, LOAD=1, RUN=2, WRITE=3)
- The ALU control decoder imports the same constants.
- A single sub-module, `step_counter`, is natural. It has a CNT_W-bit counter with clear, enable and a terminal flag at WIDTH-1.
- The FSM and output decode live in `mul_seq_ctl`.

## Test plan
- Reset then idle, no issue → all outputs 0 and step_cnt=0 for 10 cycles.
- `multu` (funct=25) at cycle 5:
  - mul_load at cycle 6
  - mul_step at cycles 7–38 (32 pulses)
  - hilo_wr=done=1 and mul_op=63 at cycle 39
  - busy=0 at cycle 40
- `mflo` (funct=18) presented continuously from cycle 10 after a cycle-5 `multu`:
  - stall=1 for cycles 10–39
  - stall=0 at cycle 40
- `add` (funct=32) during RUN → stall=0 every cycle, and step count is unaffected.
- Second `multu` during RUN → stall=1. It is accepted in the first IDLE cycle after WRITE, and mul_load fires one cycle later.
- rst=1 at step_cnt=17 → next cycle state IDLE, step_cnt=0, and no hilo_wr ever for that multiply.

Source files
------------

// File: rtl/mul_seq_ctl_pkg.sv
// mul_pkg: function codes, HiLo-open opcode and sequencer state encoding shared with the ALU control decoder
package mul_pkg;
   localparam logic [5:0] F_MULTU   = 6'd25;
   localparam logic [5:0] F_MFHI    = 6'd16;
   localparam logic [5:0] F_MFLO    = 6'd18;
   localparam logic [5:0] HILO_OPEN = 6'b111111;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2,
      S_WRITE = 2'd3
   } state_e;
   function automatic logic uses_hilo(input logic [5:0] f);
      return f == F_MULTU || f == F_MFHI || f == F_MFLO;
   endfunction
endpackage

// File: rtl/mul_seq_ctl_if.sv
// mul_seq_ctl_if: decode-side issue signals and multiplier/HiLo control bundle
interface mul_seq_ctl_if #(parameter int CNT_W = 6);
   logic             issue_valid;
   logic [5:0]       funct;
   logic             mul_load;
   logic             mul_step;
   logic             hilo_wr;
   logic [5:0]       mul_op;
   logic [CNT_W-1:0] step_cnt;
   logic             busy;
   logic             stall;
   logic             done;
   modport master (
      output issue_valid, funct,
      input  mul_load, mul_step, hilo_wr, mul_op, step_cnt, busy, stall, done
   );
   modport slave (
      input  issue_valid, funct,
      output mul_load, mul_step, hilo_wr, mul_op, step_cnt, busy, stall, done
   );
endinterface

// File: rtl/mul_seq_ctl_step_counter.sv
// step_counter: multiply step counter with clear, enable and terminal flag at WIDTH-1
module step_counter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             last_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   assign cnt_o  = cnt_q;
   assign last_o = cnt_q == CNT_W'(WIDTH - 1);
endmodule

// File: rtl/mul_seq_ctl.sv
// mul_seq_ctl: sequences the shift-add multiplier through load, WIDTH steps and one HiLo write
module mul_seq_ctl
   import mul_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic         clk,
   input logic         rst,
   mul_seq_ctl_if.slave bus
);
   state_e state_q, state_d;
   logic   accept, last;
   assign accept = bus.issue_valid && bus.funct == F_MULTU && state_q == S_IDLE;
   step_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (accept),
      .en_i  (state_q == S_RUN),
      .cnt_o (bus.step_cnt),
      .last_o(last)
   );
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  state_d = accept ? S_LOAD : S_IDLE;
         S_LOAD:  state_d = S_RUN;
         S_RUN:   state_d = last ? S_WRITE : S_RUN;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   assign bus.mul_load = state_q == S_LOAD;
   assign bus.mul_step = state_q == S_RUN;
   assign bus.hilo_wr  = state_q == S_WRITE;
   assign bus.done     = state_q == S_WRITE;
   assign bus.busy     = state_q != S_IDLE;
   assign bus.mul_op   = (state_q == S_LOAD || state_q == S_RUN) ? F_MULTU :
                         state_q == S_WRITE ? HILO_OPEN : 6'd0;
   // an accepting multu sees busy=0, so it is never stalled by itself
   assign bus.stall    = bus.busy && bus.issue_valid && uses_hilo(bus.funct);
endmodule
